// File: rtl/fmap_port_arbiter_pkg.sv
// Shared widths, requester ids and small helper types for the feature-map port arbiter.
// Pure definitions: no latency and no flow control.
package fmap_port_arbiter_pkg;

    localparam int FMAP_DATA_W = 288;
    localparam int FMAP_ADDR_W = 9;
    localparam int FMAP_DEPTH  = 464;
    localparam int NUM_REQ     = 3;

    typedef logic [1:0] req_id_t;

    localparam req_id_t REQ_LOAD = 2'd0;
    localparam req_id_t REQ_CONV = 2'd1;
    localparam req_id_t REQ_WB   = 2'd2;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } lock_t;

    function automatic req_id_t next_id(input req_id_t id);
        return (id >= REQ_WB) ? REQ_LOAD : req_id_t'(id + 2'd1);
    endfunction

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input req_id_t id);
        logic [NUM_REQ-1:0] oh;
        oh = '0;
        if (id < 2'(NUM_REQ)) begin
            oh[id] = 1'b1;
        end
        return oh;
    endfunction

endpackage

// File: rtl/fmap_port_arbiter_rr_arbiter3.sv
// Three-way round-robin grant with lock override; purely combinational (zero latency).
// No backpressure: a request that loses simply stays asserted until granted.
module rr_arbiter3
    import fmap_port_arbiter_pkg::*;
(
    input  logic [2:0] req,
    input  req_id_t    rr_ptr,
    input  lock_t      lock_owner,
    output logic [2:0] gnt,
    output logic       gnt_vld,
    output req_id_t    gnt_id,
    output logic       gnt_locked,
    output req_id_t    rr_ptr_nxt
);

    req_id_t cand;

    always_comb begin
        gnt        = 3'b000;
        gnt_vld    = 1'b0;
        gnt_id     = REQ_LOAD;
        gnt_locked = 1'b0;
        rr_ptr_nxt = rr_ptr;
        cand       = rr_ptr;

        if (lock_owner.vld && req[lock_owner.id]) begin
            // A held lock bypasses the rotation and leaves the pointer alone.
            gnt_vld    = 1'b1;
            gnt_id     = lock_owner.id;
            gnt_locked = 1'b1;
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (!gnt_vld && req[cand]) begin
                    gnt_vld = 1'b1;
                    gnt_id  = cand;
                end
                cand = next_id(cand);
            end
            if (gnt_vld) begin
                rr_ptr_nxt = next_id(gnt_id);
            end
        end

        if (gnt_vld) begin
            gnt = id_to_onehot(gnt_id);
        end
    end

endmodule

// File: rtl/fmap_port_arbiter.sv
// Shares one feature-map SRAM port among loader, conv reader and writeback; grant same cycle, read data +1 cycle.
// No queueing: losers hold req until gnt; one access per cycle, out-of-range accesses are consumed and flagged.
module fmap_port_arbiter
    import fmap_port_arbiter_pkg::*;
#(
    parameter int DATA_W = FMAP_DATA_W,
    parameter int ADDR_W = FMAP_ADDR_W,
    parameter int DEPTH  = FMAP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [2:0]            lock,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            gnt,
    output logic [2:0]            rvalid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  oor_err,
    output logic [1:0]            oor_id,
    output logic                  featureMap_sram_ena,
    output logic                  featureMap_sram_wea,
    output logic [ADDR_W-1:0]     featureMap_sram_addra,
    output logic [DATA_W-1:0]     featureMap_sram_din,
    input  logic [DATA_W-1:0]     featureMap_sram_douta
);

    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

    req_id_t rr_ptr_q, rr_ptr_d, rr_ptr_nxt;
    lock_t   lock_owner_q, lock_owner_d;
    logic    gnt_vld, gnt_locked;
    req_id_t gnt_id;

    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;
    logic              we_sel;
    logic              in_range;
    logic              access_vld;

    logic [2:0] rvalid_q, rvalid_d;
    logic       rd_zero_q, rd_zero_d;
    logic       oor_err_q, oor_err_d;
    req_id_t    oor_id_q, oor_id_d;

    rr_arbiter3 u_rr (
        .req        (req),
        .rr_ptr     (rr_ptr_q),
        .lock_owner (lock_owner_q),
        .gnt        (gnt),
        .gnt_vld    (gnt_vld),
        .gnt_id     (gnt_id),
        .gnt_locked (gnt_locked),
        .rr_ptr_nxt (rr_ptr_nxt)
    );

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        we_sel    = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                addr_sel  = addr[i*ADDR_W +: ADDR_W];
                wdata_sel = wdata[i*DATA_W +: DATA_W];
                we_sel    = we[i];
            end
        end
        in_range   = ({1'b0, addr_sel} < DEPTH_LIM);
        access_vld = gnt_vld && in_range;
    end

    // Out-of-range grants never reach the macro; address and data are parked at zero.
    always_comb begin
        featureMap_sram_ena   = access_vld;
        featureMap_sram_wea   = access_vld && we_sel;
        featureMap_sram_addra = access_vld ? addr_sel : '0;
        featureMap_sram_din   = access_vld ? wdata_sel : '0;
    end

    always_comb begin
        rr_ptr_d = gnt_vld ? rr_ptr_nxt : rr_ptr_q;

        // The latest grant decides ownership; no grant means the owner dropped req.
        lock_owner_d.vld = gnt_vld && lock[gnt_id];
        lock_owner_d.id  = gnt_vld ? gnt_id : lock_owner_q.id;

        rvalid_d  = (gnt_vld && !we_sel) ? gnt : 3'b000;
        rd_zero_d = !in_range;
        oor_err_d = gnt_vld && !in_range;
        oor_id_d  = oor_err_d ? gnt_id : REQ_LOAD;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q     <= REQ_LOAD;
            lock_owner_q <= '0;
            rvalid_q     <= 3'b000;
            rd_zero_q    <= 1'b0;
            oor_err_q    <= 1'b0;
            oor_id_q     <= REQ_LOAD;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            lock_owner_q <= lock_owner_d;
            rvalid_q     <= rvalid_d;
            rd_zero_q    <= rd_zero_d;
            oor_err_q    <= oor_err_d;
            oor_id_q     <= oor_id_d;
        end
    end

    always_comb begin
        rvalid  = rvalid_q;
        rdata   = ((|rvalid_q) && !rd_zero_q) ? featureMap_sram_douta : '0;
        oor_err = oor_err_q;
        oor_id  = oor_id_q;
    end

    gnt_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    gnt_subset_a: assert property (@(posedge clk) disable iff (rst) (gnt & ~req) == 3'b000);
    rvalid_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(rvalid));

endmodule
